bary_div_sched: RTL and testbench
=================================

Name: bary_div_sched

Overview:
Time-multiplexes one recoded-float (33-bit recFN, exp 8 / sig 24) divider across the three barycentric quotients of each fragment: a = A0/A3, b = A1/A3, c = A2/A3.
- Accepts per-fragment area jobs from the area stage into a small job FIFO.
- Issues three divides per job, in order, to the shared divider and collects the results.
- Presents {a,b,c,tag} downstream with a valid/ready handshake.
- Replaces three parallel dividers in the fragment interpolator, trading throughput for area.

Parameters:
DEPTH, 4, job FIFO entries; power of two, >= 2
TAG_W, 8, width of the opaque fragment tag carried with each job

Ports:
clk  in  1  clock; all logic on posedge
resetn  in  1  synchronous, active-low reset
in_valid  in  1  job offered
in_ready  out  1  job FIFO not full
in_tag  in  TAG_W  fragment tag
in_a0  in  33  recFN area for a (numerator 0)
in_a1  in  33  recFN area for b (numerator 1)
in_a2  in  33  recFN area for c (numerator 2)
in_a3  in  33  recFN full triangle area (common denominator)
div_in_valid  out  1  operands offered to divider
div_in_ready  in  1  divider can accept
div_a  out  33  dividend
div_b  out  33  divisor (always the job's A3)
div_out_valid  in  1  one-cycle quotient strobe from divider
div_out  in  33  quotient
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
out_a  out  33  quotient a
out_b  out  33  quotient b
out_c  out  33  quotient c
out_tag  out  TAG_W  tag of result
busy  out  1  FSM not IDLE or FIFO not empty
stray_err  out  1  sticky: div_out_valid seen outside WAIT

Behaviour:
- Reset: resetn sampled low at posedge clears the following.
  - FIFO pointers and count go to 0; FSM goes to IDLE; idx = 0.
  - All outputs go to 0, except in_ready = 1 after reset.
  - Mid-operation reset discards the queued job, the in-flight job and any pending result; no output is produced for them.
  - The divider is reset by the same resetn.
- FIFO:
  - Push on in_valid && in_ready; pop when IDLE loads a job.
  - in_ready = (count != DEPTH), registered-free, combinational from count.
  - Push and pop in the same cycle leave count unchanged; push is legal when full only if a pop happens in the same cycle is NOT supported: in_ready stays low at full.
  - Pointers wrap modulo DEPTH.
- FSM:
  - IDLE: if FIFO not empty, pop the head into working regs {tag,A0..A3}, set idx = 0, go to ISSUE. Otherwise stay.
  - ISSUE: div_in_valid = 1, div_a = A[idx], div_b = A3. Operands are held stable until div_in_valid && div_in_ready, then go to WAIT. div_in_valid is 0 in all other states.
  - WAIT: on div_out_valid, capture div_out into q[idx]. If idx == 2 go to DONE, else increment idx and go to ISSUE.
  - DONE: out_valid = 1 and outputs are held stable. On out_ready, go to IDLE.
- Latency and ordering:
  - Minimum latency from push to out_valid is 2 + 3*(divider issue-to-result latency + 1) cycles.
  - Results leave in push order.
- stray_err: set when div_out_valid = 1 while state != WAIT; cleared only by reset. The stray quotient is ignored.
- No arithmetic is performed here. Rounding mode and exceptions remain the divider's concern.

Optional Feature:
BARY_DIV_ZERO_BYPASS_EN
- Defined: in IDLE, a popped job whose A3 is recFN zero (bits [31:29] == 3'b000) skips ISSUE and WAIT.
  - It goes directly to DONE with out_a = out_b = out_c = 0 and out_tag as pushed.
  - No divide is issued for that job.
- Undefined: zero-area jobs are divided normally, and the divider's inf/NaN results pass through.

Test Plan:
- Single job, tag 0x5A, A0 = 1.0 (0x080000000), A1 = 2.0 (0x080800000), A2 = 1.0, A3 = 4.0 (0x081000000), model divider latency 5, out_ready = 1:
  - Exactly three div handshakes, with div_a = A0, then A1, then A2, and div_b = A3 each time.
  - out_a = 0x07F000000, out_b = 0x07F800000, out_c = 0x07F000000, out_tag = 0x5A.
- Push DEPTH+1 jobs back-to-back with the divider stalled (div_in_ready = 0):
  - in_ready drops after the FSM has popped one job and the FIFO holds DEPTH.
  - After release, all jobs complete with tags in push order.
- Hold out_ready = 0 for 10 cycles in DONE:
  - out_valid stays high with stable data.
  - No new div_in_valid until out_ready pulses.
- Assert resetn = 0 for 1 cycle while in WAIT with 2 jobs queued:
  - Next cycle: busy = 0, in_ready = 1, out_valid = 0.
  - No result is ever emitted for the flushed jobs.
- Pulse div_out_valid while in IDLE:
  - stray_err goes to 1 and stays 1; subsequent jobs still complete correctly.
- With BARY_DIV_ZERO_BYPASS_EN and A3 = 0x000000000:
  - No div_in_valid is asserted; out_valid is high 2 cycles after push, with a = b = c = 0.

Source files
------------

// File: rtl/bary_div_sched.sv
// Shares one recFN divider across the a/b/c barycentric quotients of each job.
// Optional: BARY_DIV_ZERO_BYPASS_EN skips the divides for zero-area jobs.
module bary_div_sched #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [32:0]      in_a0,
    input  logic [32:0]      in_a1,
    input  logic [32:0]      in_a2,
    input  logic [32:0]      in_a3,
    output logic             div_in_valid,
    input  logic             div_in_ready,
    output logic [32:0]      div_a,
    output logic [32:0]      div_b,
    input  logic             div_out_valid,
    input  logic [32:0]      div_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [32:0]      out_a,
    output logic [32:0]      out_b,
    output logic [32:0]      out_c,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy,
    output logic             stray_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = TAG_W + 4 * 33;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t state, state_nxt;

    logic [EW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             push, pop;
    logic [1:0]       idx, idx_nxt;

    logic [TAG_W-1:0] h_tag;
    logic [32:0]      h_a0, h_a1, h_a2, h_a3;

    logic [TAG_W-1:0] tag_r;
    logic [32:0]      a0_r, a1_r, a2_r, a3_r;
    logic [32:0]      q0, q1, q2;
    logic             stray_r;

    assign {h_tag, h_a0, h_a1, h_a2, h_a3} = mem[rd_ptr];

    assign in_ready  = (count != (AW+1)'(DEPTH));
    assign push      = in_valid && in_ready;
    assign busy      = (state != IDLE) || (count != '0);
    assign out_valid = (state == DONE);
    assign out_a     = q0;
    assign out_b     = q1;
    assign out_c     = q2;
    assign out_tag   = tag_r;
    assign div_b     = a3_r;
    assign stray_err = stray_r;

    always_comb begin
        div_a = a2_r;
        case (idx)
            2'd0:    div_a = a0_r;
            2'd1:    div_a = a1_r;
            default: div_a = a2_r;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        div_in_valid = 1'b0;
        pop          = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    idx_nxt   = 2'd0;
                    state_nxt = ISSUE;
`ifdef BARY_DIV_ZERO_BYPASS_EN
                    // Zero-area triangle: result is forced to zero, no divides.
                    if (h_a3[31:29] == 3'b000)
                        state_nxt = DONE;
`endif
                end
            end
            ISSUE: begin
                div_in_valid = 1'b1;
                if (div_in_ready)
                    state_nxt = WAIT;
            end
            WAIT: begin
                if (div_out_valid) begin
                    if (idx == 2'd2) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt   = idx + 2'd1;
                        state_nxt = ISSUE;
                    end
                end
            end
            DONE: begin
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {in_tag, in_a0, in_a1, in_a2, in_a3};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            idx     <= 2'd0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            tag_r   <= '0;
            a0_r    <= '0;
            a1_r    <= '0;
            a2_r    <= '0;
            a3_r    <= '0;
            q0      <= '0;
            q1      <= '0;
            q2      <= '0;
            stray_r <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (!push && pop)
                count <= count - 1'b1;
            // Quotients clear on load so a bypassed job reports zeros.
            if (pop) begin
                tag_r <= h_tag;
                a0_r  <= h_a0;
                a1_r  <= h_a1;
                a2_r  <= h_a2;
                a3_r  <= h_a3;
                q0    <= '0;
                q1    <= '0;
                q2    <= '0;
            end
            if (state == WAIT && div_out_valid) begin
                case (idx)
                    2'd0:    q0 <= div_out;
                    2'd1:    q1 <= div_out;
                    default: q2 <= div_out;
                endcase
            end
            if (div_out_valid && state != WAIT)
                stray_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bary_div_sched.sv
// Directed bench for bary_div_sched with a behavioural divider and result model.
// Define BARY_DIV_ZERO_BYPASS_EN to exercise the zero-area bypass.
module tb_bary_div_sched;

    localparam int DEPTH = 4;
    localparam int TAG_W = 8;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [TAG_W-1:0] in_tag = '0;
    logic [32:0]      in_a0 = '0, in_a1 = '0, in_a2 = '0, in_a3 = '0;
    logic             div_in_valid;
    logic             div_in_ready = 1'b1;
    logic [32:0]      div_a, div_b;
    logic             div_out_valid = 1'b0;
    logic [32:0]      div_out = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [32:0]      out_a, out_b, out_c;
    logic [TAG_W-1:0] out_tag;
    logic             busy, stray_err;

    always #5 clk = ~clk;

    bary_div_sched #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
        .in_a0(in_a0), .in_a1(in_a1), .in_a2(in_a2), .in_a3(in_a3),
        .div_in_valid(div_in_valid), .div_in_ready(div_in_ready),
        .div_a(div_a), .div_b(div_b),
        .div_out_valid(div_out_valid), .div_out(div_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_tag(out_tag),
        .busy(busy), .stray_err(stray_err)
    );

    int checks = 0;
    int errors = 0;
    int lat = 5;
    int div_hs = 0;
    int out_cnt = 0;
    logic stray_req = 1'b0;

    logic [32:0]      last_a, last_b, last_c;
    logic [TAG_W-1:0] last_tag;

    // Divider stand-in: exact quotient for zero-mantissa recFN powers of two.
    function automatic logic [32:0] fdiv(logic [32:0] n, logic [32:0] d);
        return n - d + 33'h080000000;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Divider model
    logic        dv_pend = 1'b0;
    int          dv_cnt = 0;
    logic [32:0] dv_q = '0;
    always @(negedge clk) begin
        if (!resetn) begin
            dv_pend = 1'b0;
            div_out_valid = 1'b0;
        end else begin
            div_out_valid = 1'b0;
            if (stray_req) begin
                div_out_valid = 1'b1;
                div_out = 33'h0DEADBEEF;
            end
            if (dv_pend) begin
                if (dv_cnt <= 1) begin
                    div_out_valid = 1'b1;
                    div_out = dv_q;
                    dv_pend = 1'b0;
                end else begin
                    dv_cnt--;
                end
            end
            if (div_in_valid && div_in_ready) begin
                dv_pend = 1'b1;
                dv_cnt = lat;
                dv_q = fdiv(div_a, div_b);
            end
        end
    end

    // Result model and compare
    logic [32:0]      op_a[$], op_b[$];
    logic [32:0]      ex_a[$], ex_b[$], ex_c[$];
    logic [TAG_W-1:0] ex_tag[$];
    logic             hold = 1'b0;
    logic [32:0]      h_a, h_b, h_c;
    logic [TAG_W-1:0] h_tag;

    always @(negedge clk) begin
        if (!resetn) begin
            op_a.delete(); op_b.delete();
            ex_a.delete(); ex_b.delete(); ex_c.delete(); ex_tag.delete();
            hold = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                bit byp;
                byp = 1'b0;
`ifdef BARY_DIV_ZERO_BYPASS_EN
                byp = (in_a3[31:29] == 3'b000);
`endif
                ex_tag.push_back(in_tag);
                if (byp) begin
                    ex_a.push_back('0); ex_b.push_back('0); ex_c.push_back('0);
                end else begin
                    ex_a.push_back(fdiv(in_a0, in_a3));
                    ex_b.push_back(fdiv(in_a1, in_a3));
                    ex_c.push_back(fdiv(in_a2, in_a3));
                    op_a.push_back(in_a0); op_b.push_back(in_a3);
                    op_a.push_back(in_a1); op_b.push_back(in_a3);
                    op_a.push_back(in_a2); op_b.push_back(in_a3);
                end
            end
            if (div_in_valid && div_in_ready) begin
                div_hs++;
                if (op_a.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL div_unexpected: got div_a %0h expected none", div_a);
                end else begin
                    chk("div_a", div_a, op_a.pop_front());
                    chk("div_b", div_b, op_b.pop_front());
                end
            end
            if (out_valid) begin
                chk("no_issue_in_done", div_in_valid, 0);
                if (hold) begin
                    chk("hold_a", out_a, h_a);
                    chk("hold_b", out_b, h_b);
                    chk("hold_c", out_c, h_c);
                    chk("hold_tag", out_tag, h_tag);
                end
                if (out_ready) begin
                    out_cnt++;
                    last_a = out_a; last_b = out_b;
                    last_c = out_c; last_tag = out_tag;
                    if (ex_tag.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL out_unexpected: got tag %0h expected none", out_tag);
                    end else begin
                        chk("out_a", out_a, ex_a.pop_front());
                        chk("out_b", out_b, ex_b.pop_front());
                        chk("out_c", out_c, ex_c.pop_front());
                        chk("out_tag", out_tag, ex_tag.pop_front());
                    end
                end
            end
            hold = out_valid && !out_ready;
            h_a = out_a; h_b = out_b; h_c = out_c; h_tag = out_tag;
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(logic [TAG_W-1:0] t, logic [32:0] x0, logic [32:0] x1,
                        logic [32:0] x2, logic [32:0] x3);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_tag = t; in_a0 = x0; in_a1 = x1; in_a2 = x2; in_a3 = x3;
        for (int k = 0; k < 500 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL push_timeout: got in_ready 0 expected 1 (tag %0h)", t);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_outs(int target);
        for (int k = 0; k < 2000 && out_cnt < target; k++)
            tick();
        chk("outs_done", out_cnt, target);
    endtask

    localparam logic [32:0] ONE  = 33'h080000000;
    localparam logic [32:0] TWO  = 33'h080800000;
    localparam logic [32:0] FOUR = 33'h081000000;

    initial begin
        int hs0, base;

        // Reset state
        resetn = 1'b0;
        tick(2);
        resetn = 1'b1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_div_in_valid", div_in_valid, 0);
        chk("rst_stray", stray_err, 0);
        chk("rst_out_a", out_a, 0);
        chk("rst_out_tag", out_tag, 0);

        // Single job with hand-computed quotients
        hs0 = div_hs;
        base = out_cnt;
        push(8'h5A, ONE, TWO, ONE, FOUR);
        wait_outs(base + 1);
        chk("t1_divs", div_hs - hs0, 3);
        chk("t1_a", last_a, 33'h07F000000);
        chk("t1_b", last_b, 33'h07F800000);
        chk("t1_c", last_c, 33'h07F000000);
        chk("t1_tag", last_tag, 8'h5A);

        // Fill FIFO with divider stalled
        div_in_ready = 1'b0;
        base = out_cnt;
        for (int i = 1; i <= DEPTH + 1; i++)
            push(TAG_W'(i), ONE + (33'(i) << 23), TWO, FOUR + (33'(i) << 23), TWO);
        chk("full_in_ready", in_ready, 0);
        chk("full_busy", busy, 1);
        tick(3);
        chk("stall_in_ready", in_ready, 0);
        div_in_ready = 1'b1;
        wait_outs(base + DEPTH + 1);
        chk("fill_last_tag", last_tag, DEPTH + 1);

        // Hold results in DONE
        out_ready = 1'b0;
        base = out_cnt;
        push(8'h33, TWO, ONE, FOUR, ONE);
        push(8'h34, FOUR, FOUR, TWO, TWO);
        for (int k = 0; k < 500 && !out_valid; k++)
            tick();
        chk("t3_valid", out_valid, 1);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("t3_hold_valid", out_valid, 1);
            chk("t3_no_issue", div_in_valid, 0);
        end
        out_ready = 1'b1;
        wait_outs(base + 2);
        chk("t3_tag", last_tag, 8'h34);

        // Reset while waiting on the divider
        lat = 20;
        hs0 = div_hs;
        base = out_cnt;
        push(8'h41, ONE, ONE, ONE, TWO);
        push(8'h42, TWO, TWO, TWO, TWO);
        push(8'h43, FOUR, FOUR, FOUR, TWO);
        for (int k = 0; k < 200 && div_hs == hs0; k++)
            tick();
        tick(2);
        chk("t4_busy_before", busy, 1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("t4_busy", busy, 0);
        chk("t4_in_ready", in_ready, 1);
        chk("t4_out_valid", out_valid, 0);
        tick(60);
        chk("t4_no_output", out_cnt, base);
        lat = 5;

        // Stray quotient strobe while idle
        chk("t5_stray_before", stray_err, 0);
        stray_req = 1'b1;
        tick();
        stray_req = 1'b0;
        tick();
        chk("t5_stray_set", stray_err, 1);
        base = out_cnt;
        push(8'h77, FOUR, TWO, ONE, TWO);
        wait_outs(base + 1);
        chk("t5_a", last_a, 33'h080800000);
        chk("t5_tag", last_tag, 8'h77);
        chk("t5_stray_sticky", stray_err, 1);

        // Zero-area job
        hs0 = div_hs;
        base = out_cnt;
`ifdef BARY_DIV_ZERO_BYPASS_EN
        push(8'h99, ONE, TWO, FOUR, 33'h000000000);
        chk("t6_not_yet", out_valid, 0);
        tick();
        chk("t6_valid", out_valid, 1);
        chk("t6_a", out_a, 0);
        chk("t6_b", out_b, 0);
        chk("t6_c", out_c, 0);
        chk("t6_tag", out_tag, 8'h99);
        wait_outs(base + 1);
        chk("t6_no_div", div_hs - hs0, 0);
`else
        push(8'h99, ONE, TWO, FOUR, 33'h000000000);
        wait_outs(base + 1);
        chk("t6_divs", div_hs - hs0, 3);
        chk("t6_tag", last_tag, 8'h99);
`endif
        tick(3);
        chk("end_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
